// File: rtl/ifu_fetch_resp_pkg.sv
// ---------------------------------------------------------------------------
// sysconfig: shared configuration for the instruction fetch responder.
//   XLEN          - address / PC width
//   INST_LEN      - instruction width
//   PC_RESET_ADDR - PC value after reset
//   ST_*          - fetch FSM state encoding, plus the matching enum type
// ---------------------------------------------------------------------------
package sysconfig;

    localparam int XLEN     = 64;
    localparam int INST_LEN = 32;

    localparam logic [XLEN-1:0] PC_RESET_ADDR = 64'h0000_0000_8000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_HOLD = ST_HOLD
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_resp_regtemplate.sv
// ---------------------------------------------------------------------------
// regTemplate: enable-gated data register with synchronous active-low reset.
//   clk  - clock
//   rst  - synchronous reset, active low; loads RST_VAL
//   i_en - load i_d on the next rising edge
//   i_d  - next value
//   o_q  - registered value
// ---------------------------------------------------------------------------
module regTemplate #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ifu_fetch_resp.sv
// ---------------------------------------------------------------------------
// ifu_fetch_resp: responder end of the PC-to-fetch interface. Accepts the
// next-PC request, runs one outstanding instruction-memory read, and hands
// the instruction plus its PC to decode over valid/ready. Redirects that
// arrive with a read in flight kill that read and are refetched afterwards.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   pc_next_i, read_req_i    fetch request from the PC stage
//   stall_o                  back-pressure to the PC stage
//   redirect_valid_i/pc_i    branch or trap redirect
//   mem_req_o, mem_addr_o    memory read request, word-aligned address
//   mem_gnt_i                request accepted by memory
//   mem_rvalid_i/rdata_i     read response
//   inst_valid_o/ready_i     handshake to decode
//   inst_o, inst_pc_o        fetched instruction and its PC
// ---------------------------------------------------------------------------
module ifu_fetch_resp
    import sysconfig::*;
#(
    parameter int                XLEN     = sysconfig::XLEN,
    parameter int                INST_LEN = sysconfig::INST_LEN,
    parameter logic [XLEN-1:0]   RESET_PC = PC_RESET_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     pc_next_i,
    input  logic                read_req_i,
    output logic                stall_o,
    input  logic                redirect_valid_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                mem_req_o,
    output logic [XLEN-1:0]     mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [31:0]         mem_rdata_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [INST_LEN-1:0] inst_o,
    output logic [XLEN-1:0]     inst_pc_o
);

    fetch_state_t        r_state, w_state_nxt;
    logic [XLEN-1:0]     r_addr, w_addr_d, r_pend_pc;
    logic                r_kill, w_kill_d, r_pend, w_pend_d;
    logic                w_addr_en, w_pend_pc_en, w_inst_en, w_accept;
    logic [INST_LEN-1:0] w_inst_d;

    assign stall_o      = (r_state == S_REQ) || (r_state == S_WAIT) ||
                          ((r_state == S_HOLD) && !inst_ready_i) || r_pend;
    assign w_accept     = read_req_i && !stall_o && !redirect_valid_i;
    assign mem_req_o    = (r_state == S_REQ);
    assign mem_addr_o   = {r_addr[XLEN-1:2], 2'b00};
    assign inst_valid_o = (r_state == S_HOLD) && !r_kill;

    // Odd-halfword fetch returns only the upper half; straddling instructions
    // are not supported so the top 16 bits are zero.
    assign w_inst_d = r_addr[1] ? INST_LEN'({16'b0, mem_rdata_i[31:16]})
                                : INST_LEN'(mem_rdata_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_en    = 1'b0;
        w_addr_d     = pc_next_i;
        w_kill_d     = r_kill;
        w_pend_d     = r_pend;
        w_pend_pc_en = 1'b0;
        w_inst_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid_i) begin
                    w_addr_en   = 1'b1;
                    w_addr_d    = redirect_pc_i;
                    w_state_nxt = S_REQ;
                end else if (w_accept) begin
                    w_addr_en   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // The request stays up; its response is discarded later.
                if (redirect_valid_i) begin
                    w_kill_d     = 1'b1;
                    w_pend_d     = 1'b1;
                    w_pend_pc_en = 1'b1;
                end
                if (mem_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i && (r_kill || redirect_valid_i)) begin
                    // Data is dropped; the newest redirect target is refetched.
                    w_kill_d = 1'b0;
                    w_pend_d = 1'b0;
                    if (redirect_valid_i) begin
                        w_addr_en   = 1'b1;
                        w_addr_d    = redirect_pc_i;
                        w_state_nxt = S_REQ;
                    end else if (r_pend) begin
                        w_addr_en   = 1'b1;
                        w_addr_d    = r_pend_pc;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (mem_rvalid_i) begin
                    w_inst_en   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (redirect_valid_i) begin
                    w_kill_d     = 1'b1;
                    w_pend_d     = 1'b1;
                    w_pend_pc_en = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid_i) begin
                    w_addr_en   = 1'b1;
                    w_addr_d    = redirect_pc_i;
                    w_state_nxt = S_REQ;
                end else if (inst_ready_i && read_req_i) begin
                    w_addr_en   = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (inst_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    regTemplate #(.W(XLEN), .RST_VAL(RESET_PC)) u_addr (
        .clk(clk), .rst(rst), .i_en(w_addr_en), .i_d(w_addr_d), .o_q(r_addr)
    );

    regTemplate #(.W(1), .RST_VAL(1'b0)) u_kill (
        .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_kill_d), .o_q(r_kill)
    );

    regTemplate #(.W(1), .RST_VAL(1'b0)) u_pend (
        .clk(clk), .rst(rst), .i_en(1'b1), .i_d(w_pend_d), .o_q(r_pend)
    );

    regTemplate #(.W(XLEN), .RST_VAL(RESET_PC)) u_pend_pc (
        .clk(clk), .rst(rst), .i_en(w_pend_pc_en), .i_d(redirect_pc_i), .o_q(r_pend_pc)
    );

    regTemplate #(.W(INST_LEN), .RST_VAL('0)) u_inst (
        .clk(clk), .rst(rst), .i_en(w_inst_en), .i_d(w_inst_d), .o_q(inst_o)
    );

    regTemplate #(.W(XLEN), .RST_VAL(RESET_PC)) u_inst_pc (
        .clk(clk), .rst(rst), .i_en(w_inst_en), .i_d(r_addr), .o_q(inst_pc_o)
    );

endmodule

// File: tb/tb_ifu_fetch_resp.sv
module tb_ifu_fetch_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] pc_next_i = '0;
    logic        read_req_i = 1'b0;
    logic        stall_o;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch_resp dut (
        .clk(clk), .rst(rst),
        .pc_next_i(pc_next_i), .read_req_i(read_req_i), .stall_o(stall_o),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept a fetch from IDLE; returns in REQ.
    task automatic start_fetch(input logic [63:0] pc);
        read_req_i = 1'b1;
        pc_next_i  = pc;
        tick();
        read_req_i = 1'b0;
    endtask

    // Grant in REQ, respond one cycle later; returns in HOLD.
    task automatic grant_and_return(input logic [31:0] data);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        checks++; if (inst_pc_o !== 64'h80000000) begin errors++; $display("FAIL reset_inst_pc: got %h expected 80000000", inst_pc_o); end
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst_o); end
        checks++; if (mem_addr_o !== 64'h80000000) begin errors++; $display("FAIL reset_addr: got %h expected 80000000", mem_addr_o); end
    endtask

    task automatic test_fetch;
        inst_ready_i = 1'b1;
        read_req_i   = 1'b1;
        pc_next_i    = 64'h80000004;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL fetch_idle_stall: got %b expected 0", stall_o); end
        tick();
        read_req_i = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b expected 1", mem_req_o); end
        checks++; if (mem_addr_o !== 64'h80000004) begin errors++; $display("FAIL fetch_addr: got %h expected 80000004", mem_addr_o); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL fetch_req_stall: got %b expected 1", stall_o); end
        grant_and_return(32'h00A00093);
        #1;
        checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b expected 1", inst_valid_o); end
        checks++; if (inst_o !== 32'h00A00093) begin errors++; $display("FAIL fetch_inst: got %h expected 00a00093", inst_o); end
        checks++; if (inst_pc_o !== 64'h80000004) begin errors++; $display("FAIL fetch_inst_pc: got %h expected 80000004", inst_pc_o); end
        tick();
        #1;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_valid_once: got %b expected 0", inst_valid_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_idle_req: got %b expected 0", mem_req_o); end
    endtask

    task automatic test_halfword;
        inst_ready_i = 1'b1;
        start_fetch(64'h80000002);
        #1;
        checks++; if (mem_addr_o !== 64'h80000000) begin errors++; $display("FAIL half_addr: got %h expected 80000000", mem_addr_o); end
        grant_and_return(32'h45051234);
        #1;
        checks++; if (inst_o !== 32'h00004505) begin errors++; $display("FAIL half_inst: got %h expected 00004505", inst_o); end
        checks++; if (inst_pc_o !== 64'h80000002) begin errors++; $display("FAIL half_inst_pc: got %h expected 80000002", inst_pc_o); end
        tick();
    endtask

    task automatic test_redirect_wait;
        inst_ready_i = 1'b1;
        start_fetch(64'h80000010);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i        = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h80000100;
        tick();
        redirect_valid_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL redir_wait_stall: got %b expected 1", stall_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL redir_wait_req: got %b expected 0", mem_req_o); end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL redir_killed_valid: got %b expected 0", inst_valid_o); end
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL redir_refetch_req: got %b expected 1", mem_req_o); end
        checks++; if (mem_addr_o !== 64'h80000100) begin errors++; $display("FAIL redir_refetch_addr: got %h expected 80000100", mem_addr_o); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL redir_refetch_stall: got %b expected 1", stall_o); end
        grant_and_return(32'h00000013);
        #1;
        checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL redir_new_valid: got %b expected 1", inst_valid_o); end
        checks++; if (inst_o !== 32'h00000013) begin errors++; $display("FAIL redir_new_inst: got %h expected 00000013", inst_o); end
        checks++; if (inst_pc_o !== 64'h80000100) begin errors++; $display("FAIL redir_new_pc: got %h expected 80000100", inst_pc_o); end
        tick();
    endtask

    task automatic test_redirect_same_cycle;
        inst_ready_i = 1'b1;
        start_fetch(64'h80000040);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i        = 1'b0;
        mem_rvalid_i     = 1'b1;
        mem_rdata_i      = 32'hCAFEF00D;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h80000200;
        tick();
        mem_rvalid_i     = 1'b0;
        redirect_valid_i = 1'b0;
        #1;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL same_valid: got %b expected 0", inst_valid_o); end
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL same_req: got %b expected 1", mem_req_o); end
        checks++; if (mem_addr_o !== 64'h80000200) begin errors++; $display("FAIL same_addr: got %h expected 80000200", mem_addr_o); end
        grant_and_return(32'h00100073);
        #1;
        checks++; if (inst_pc_o !== 64'h80000200) begin errors++; $display("FAIL same_inst_pc: got %h expected 80000200", inst_pc_o); end
        tick();
    endtask

    task automatic test_back_to_back;
        inst_ready_i = 1'b0;
        start_fetch(64'h80000020);
        grant_and_return(32'h12345678);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, inst_valid_o); end
            checks++; if (inst_o !== 32'h12345678) begin errors++; $display("FAIL hold_inst[%0d]: got %h expected 12345678", i, inst_o); end
            checks++; if (inst_pc_o !== 64'h80000020) begin errors++; $display("FAIL hold_pc[%0d]: got %h expected 80000020", i, inst_pc_o); end
            checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d]: got %b expected 1", i, stall_o); end
            tick();
        end
        inst_ready_i = 1'b1;
        read_req_i   = 1'b1;
        pc_next_i    = 64'h80000008;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", stall_o); end
        tick();
        read_req_i = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b expected 1", mem_req_o); end
        checks++; if (mem_addr_o !== 64'h80000008) begin errors++; $display("FAIL b2b_addr: got %h expected 80000008", mem_addr_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", inst_valid_o); end
        grant_and_return(32'hAAAA5555);
        #1;
        checks++; if (inst_o !== 32'hAAAA5555) begin errors++; $display("FAIL b2b_inst: got %h expected aaaa5555", inst_o); end
        tick();
    endtask

    task automatic test_reset_mid;
        inst_ready_i = 1'b1;
        start_fetch(64'h80000030);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b expected 0", stall_o); end
        checks++; if (inst_pc_o !== 64'h80000000) begin errors++; $display("FAIL rmid_inst_pc: got %h expected 80000000", inst_pc_o); end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00000055;
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", inst_valid_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b expected 0", mem_req_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rmid_stall_after: got %b expected 0", stall_o); end
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rmid_inst: got %h expected 0", inst_o); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_halfword();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
